// File: rtl/cu_pkg.sv
// ============================================================================
// cu_pkg : opcodes, FS codes, state/PC-mode enums and register constants
// Rev 1.0
// ============================================================================
`default_nettype none

package cu_pkg;

  localparam int c_nbit  = 16;
  localparam int c_off_w = 6;

  localparam logic [6:0] c_op_ld  = 7'b0010000;
  localparam logic [6:0] c_op_st  = 7'b0100000;
  localparam logic [6:0] c_op_ldi = 7'b1001100;
  localparam logic [6:0] c_op_adi = 7'b1000010;
  localparam logic [6:0] c_op_lri = 7'b0010001;
  localparam logic [6:0] c_op_brz = 7'b1100000;
  localparam logic [6:0] c_op_brn = 7'b1100001;
  localparam logic [6:0] c_op_jmp = 7'b1110000;
  localparam logic [6:0] c_op_hlt = 7'b1111111;

  localparam logic [3:0] c_fs_mova = 4'b0000;
  localparam logic [3:0] c_fs_inc  = 4'b0001;
  localparam logic [3:0] c_fs_add  = 4'b0010;
  localparam logic [3:0] c_fs_sub  = 4'b0101;
  localparam logic [3:0] c_fs_dec  = 4'b0110;
  localparam logic [3:0] c_fs_and  = 4'b1000;
  localparam logic [3:0] c_fs_or   = 4'b1001;
  localparam logic [3:0] c_fs_xor  = 4'b1010;
  localparam logic [3:0] c_fs_not  = 4'b1011;
  localparam logic [3:0] c_fs_movb = 4'b1100;
  localparam logic [3:0] c_fs_shr  = 4'b1101;
  localparam logic [3:0] c_fs_shl  = 4'b1110;

  localparam logic [3:0] c_r8_addr = 4'b1000;

  typedef enum logic [1:0] {
    ST_INF  = 2'd0,
    ST_EX0  = 2'd1,
    ST_EX1  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_mode_t;

  function automatic logic fs_valid(input logic [3:0] fs);
    case (fs)
      c_fs_mova, c_fs_inc, c_fs_add, c_fs_sub, c_fs_dec, c_fs_and,
      c_fs_or, c_fs_xor, c_fs_not, c_fs_movb, c_fs_shr, c_fs_shl: fs_valid = 1'b1;
      default: fs_valid = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit : program counter with hold / increment / relative branch / jump
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_unit
  import cu_pkg::*;
#(
  parameter int NBIT = 16
) (
  input  logic                 clk_main,
  input  logic                 reset,
  input  pc_mode_t             i_mode,
  input  logic [c_off_w-1:0]   i_offset,
  input  logic [NBIT-1:0]      i_target,
  output logic [NBIT-1:0]      o_pc
);

  logic [NBIT-1:0] r_pc;
  logic [NBIT-1:0] w_offset_ext;

  // Offset is two's complement; the sum simply wraps modulo 2^NBIT.
  assign w_offset_ext = {{(NBIT-c_off_w){i_offset[c_off_w-1]}}, i_offset};

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else begin
      case (i_mode)
        PC_INC:    r_pc <= r_pc + NBIT'(1);
        PC_BRANCH: r_pc <= r_pc + w_offset_ext;
        PC_JUMP:   r_pc <= i_target;
        default:   r_pc <= r_pc;
      endcase
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : multi-cycle fetch/decode sequencer driving the datapath word
// Rev 1.0
// ============================================================================
`default_nettype none

module control_unit
  import cu_pkg::*;
#(
  parameter int NBIT = c_nbit
) (
  input  logic            clk_main,
  input  logic            reset,
  input  logic [15:0]     instr,
  input  logic [NBIT-1:0] bus_a,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  output logic [NBIT-1:0] pc,
  output logic [2:0]      DR,
  output logic [2:0]      SA,
  output logic [2:0]      SB,
  output logic [3:0]      AX,
  output logic [3:0]      BX,
  output logic [3:0]      DX,
  output logic [3:0]      FS,
  output logic [NBIT-1:0] const_out,
  output logic            MB,
  output logic            MM,
  output logic            MD,
  output logic            MW,
  output logic            RW
);

  state_t      r_state;
  logic [15:0] r_ir;
  pc_mode_t    w_mode;
  logic [6:0]  w_opcode;
  logic [2:0]  w_dr, w_sa, w_sb;
  logic        w_unused;

  assign w_opcode = r_ir[15:9];
  assign w_dr     = r_ir[8:6];
  assign w_sa     = r_ir[5:3];
  assign w_sb     = r_ir[2:0];
  assign w_unused = ^{V, C};

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state <= ST_INF;
      r_ir    <= '0;
    end else begin
      case (r_state)
        ST_INF: begin
          r_ir    <= instr;
          r_state <= ST_EX0;
        end
        ST_EX0: begin
          if (w_opcode == c_op_lri)      r_state <= ST_EX1;
          else if (w_opcode == c_op_hlt) r_state <= ST_HALT;
          else                           r_state <= ST_INF;
        end
        ST_EX1:  r_state <= ST_INF;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    DR        = '0;
    SA        = '0;
    SB        = '0;
    AX        = '0;
    BX        = '0;
    DX        = '0;
    FS        = '0;
    const_out = '0;
    MB        = 1'b0;
    MM        = 1'b0;
    MD        = 1'b0;
    MW        = 1'b0;
    RW        = 1'b0;
    w_mode    = PC_HOLD;

    if (r_state != ST_INF) begin
      DR        = w_dr;
      SA        = w_sa;
      SB        = w_sb;
      const_out = {{(NBIT-3){1'b0}}, w_sb};
    end

    case (r_state)
      ST_INF: MM = 1'b1;
      ST_EX0: begin
        w_mode = PC_INC;
        if (w_opcode[6:4] == 3'b000) begin
          // Unlisted function codes fall through as NOP.
          if (fs_valid(w_opcode[3:0])) begin
            FS = w_opcode[3:0];
            AX = {1'b0, w_sa};
            BX = {1'b0, w_sb};
            DX = {1'b0, w_dr};
            RW = 1'b1;
          end
        end else begin
          case (w_opcode)
            c_op_ld: begin
              AX = {1'b0, w_sa};
              DX = {1'b0, w_dr};
              MD = 1'b1;
              RW = 1'b1;
            end
            c_op_st: begin
              AX = {1'b0, w_sa};
              BX = {1'b0, w_sb};
              MW = 1'b1;
            end
            c_op_ldi: begin
              DX = {1'b0, w_dr};
              MB = 1'b1;
              FS = c_fs_movb;
              RW = 1'b1;
            end
            c_op_adi: begin
              AX = {1'b0, w_sa};
              DX = {1'b0, w_dr};
              MB = 1'b1;
              FS = c_fs_add;
              RW = 1'b1;
            end
            c_op_lri: begin
              AX     = {1'b0, w_sa};
              DX     = c_r8_addr;
              MD     = 1'b1;
              RW     = 1'b1;
              w_mode = PC_HOLD;
            end
            c_op_brz: begin
              AX     = {1'b0, w_sa};
              FS     = c_fs_mova;
              w_mode = Z ? PC_BRANCH : PC_INC;
            end
            c_op_brn: begin
              AX     = {1'b0, w_sa};
              FS     = c_fs_mova;
              w_mode = N ? PC_BRANCH : PC_INC;
            end
            c_op_jmp: begin
              AX     = {1'b0, w_sa};
              FS     = c_fs_mova;
              w_mode = PC_JUMP;
            end
            c_op_hlt: w_mode = PC_HOLD;
            default:  w_mode = PC_INC;
          endcase
        end
      end
      ST_EX1: begin
        AX     = c_r8_addr;
        DX     = {1'b0, w_dr};
        MD     = 1'b1;
        RW     = 1'b1;
        w_mode = PC_INC;
      end
      default: w_mode = PC_HOLD;
    endcase
  end

  pc_unit #(
    .NBIT (NBIT)
  ) u_pc_unit (
    .clk_main (clk_main),
    .reset    (reset),
    .i_mode   (w_mode),
    .i_offset ({w_dr, w_sb}),
    .i_target (bus_a),
    .o_pc     (pc)
  );

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : scoreboard bench with an instruction-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  dr, sa, sb;
    logic [3:0]  ax, bx, dx, fs;
    logic [15:0] k;
    logic        mb, mm, md, mw, rw;
  } cw_t;

  logic        clk_main = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] instr    = '0;
  logic [15:0] bus_a    = '0;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic [15:0] pc, const_out;
  logic [2:0]  DR, SA, SB;
  logic [3:0]  AX, BX, DX, FS;
  logic        MB, MM, MD, MW, RW;

  control_unit dut (
    .clk_main (clk_main), .reset (reset), .instr (instr), .bus_a (bus_a),
    .V (V), .C (C), .N (N), .Z (Z), .pc (pc),
    .DR (DR), .SA (SA), .SB (SB), .AX (AX), .BX (BX), .DX (DX), .FS (FS),
    .const_out (const_out), .MB (MB), .MM (MM), .MD (MD), .MW (MW), .RW (RW)
  );

  always #5 clk_main = ~clk_main;

  cw_t         exp_q[$];
  string       name_q[$];
  int          checks  = 0;
  int          errors  = 0;
  logic        running = 1'b0;
  logic [15:0] mpc     = '0;

  // Instruction classes, straight from the ISA table.
  function automatic string mnem(input logic [15:0] ins);
    logic [6:0] op;
    op = ins[15:9];
    if (op[6:4] == 3'b000)
      return (op[3:0] inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd9,
                              4'd10, 4'd11, 4'd12, 4'd13, 4'd14}) ? "ALU" : "NOP";
    case (op)
      7'b0010000: return "LD";
      7'b0100000: return "ST";
      7'b1001100: return "LDI";
      7'b1000010: return "ADI";
      7'b0010001: return "LRI";
      7'b1100000: return "BRZ";
      7'b1100001: return "BRN";
      7'b1110000: return "JMP";
      7'b1111111: return "HLT";
      default:    return "NOP";
    endcase
  endfunction

  // phase: 0 fetch, 1 first execute, 2 second execute, 3 halted
  function automatic cw_t exp_cw(input logic [15:0] ins, input int phase,
                                 input logic [15:0] pcv);
    cw_t   w;
    string m;
    w    = '0;
    w.pc = pcv;
    if (phase == 0) begin
      w.mm = 1'b1;
      return w;
    end
    w.dr = ins[8:6];
    w.sa = ins[5:3];
    w.sb = ins[2:0];
    w.k  = {13'd0, ins[2:0]};
    if (phase == 3) return w;
    if (phase == 2) begin
      w.ax = 4'd8; w.dx = {1'b0, ins[8:6]}; w.md = 1'b1; w.rw = 1'b1;
      return w;
    end
    m = mnem(ins);
    if (m == "ALU") begin
      w.fs = ins[12:9]; w.ax = {1'b0, ins[5:3]}; w.bx = {1'b0, ins[2:0]};
      w.dx = {1'b0, ins[8:6]}; w.rw = 1'b1;
    end else if (m == "LD") begin
      w.ax = {1'b0, ins[5:3]}; w.dx = {1'b0, ins[8:6]}; w.md = 1'b1; w.rw = 1'b1;
    end else if (m == "ST") begin
      w.ax = {1'b0, ins[5:3]}; w.bx = {1'b0, ins[2:0]}; w.mw = 1'b1;
    end else if (m == "LDI") begin
      w.dx = {1'b0, ins[8:6]}; w.mb = 1'b1; w.fs = 4'b1100; w.rw = 1'b1;
    end else if (m == "ADI") begin
      w.ax = {1'b0, ins[5:3]}; w.dx = {1'b0, ins[8:6]}; w.mb = 1'b1;
      w.fs = 4'b0010; w.rw = 1'b1;
    end else if (m == "LRI") begin
      w.ax = {1'b0, ins[5:3]}; w.dx = 4'd8; w.md = 1'b1; w.rw = 1'b1;
    end else if (m == "BRZ" || m == "BRN" || m == "JMP") begin
      w.ax = {1'b0, ins[5:3]};
    end
    return w;
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] ins, input logic [15:0] pcv,
                                          input logic z, input logic n,
                                          input logic [15:0] ba);
    logic [5:0] off6;
    int         off;
    string      m;
    m    = mnem(ins);
    off6 = {ins[8:6], ins[2:0]};
    off  = off6[5] ? int'(off6) - 64 : int'(off6);
    if (m == "HLT") return pcv;
    if (m == "JMP") return ba;
    if ((m == "BRZ" && z) || (m == "BRN" && n)) return 16'(int'(pcv) + off);
    return 16'(int'(pcv) + 1);
  endfunction

  task automatic push(input cw_t w, input string nm);
    exp_q.push_back(w);
    name_q.push_back(nm);
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic z, input logic n,
                           input logic [15:0] ba, input string nm);
    string m;
    m       = mnem(ins);
    running = 1'b1;
    instr   = ins;
    Z       = z;
    N       = n;
    bus_a   = ba;
    V       = 1'($urandom);
    C       = 1'($urandom);
    push(exp_cw(ins, 0, mpc), {nm, ".inf"});
    @(posedge clk_main); #1;
    push(exp_cw(ins, 1, mpc), {nm, ".ex0"});
    @(posedge clk_main); #1;
    if (m == "LRI") begin
      push(exp_cw(ins, 2, mpc), {nm, ".ex1"});
      @(posedge clk_main); #1;
    end
    mpc = next_pc(ins, mpc, z, n, ba);
  endtask

  task automatic halt_cycles(input logic [15:0] ins, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      push(exp_cw(ins, 3, mpc), "halt");
      @(posedge clk_main); #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Mid-cycle asynchronous reset; outputs must react before any clock edge.
  task automatic do_reset(input string nm);
    running = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk({nm, ".pc"}, 32'(pc), 32'h0);
    chk({nm, ".mm"}, 32'(MM), 32'h1);
    chk({nm, ".rw"}, 32'(RW), 32'h0);
    chk({nm, ".mw"}, 32'(MW), 32'h0);
    exp_q.delete();
    name_q.delete();
    @(posedge clk_main); #1;
    reset = 1'b0;
    mpc   = '0;
  endtask

  always @(negedge clk_main) begin
    if (!reset && exp_q.size() > 0) begin
      cw_t   e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {pc, DR, SA, SB, AX, BX, DX, FS, const_out, MB, MM, MD, MW, RW};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: actual pc=%h dr/sa/sb=%0d/%0d/%0d ax/bx/dx/fs=%h/%h/%h/%h k=%h mb/mm/md/mw/rw=%b%b%b%b%b required pc=%h dr/sa/sb=%0d/%0d/%0d ax/bx/dx/fs=%h/%h/%h/%h k=%h mb/mm/md/mw/rw=%b%b%b%b%b",
                 nm, a.pc, a.dr, a.sa, a.sb, a.ax, a.bx, a.dx, a.fs, a.k, a.mb, a.mm, a.md, a.mw, a.rw,
                 e.pc, e.dr, e.sa, e.sb, e.ax, e.bx, e.dx, e.fs, e.k, e.mb, e.mm, e.md, e.mw, e.rw);
      end
    end else if (!reset && running) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underrun: actual empty required entry");
    end
  end

  initial begin
    logic [15:0] ins;
    logic [6:0]  op_tab [0:8];
    op_tab = '{7'b0010000, 7'b0100000, 7'b1001100, 7'b1000010, 7'b0010001,
               7'b1100000, 7'b1100001, 7'b1110000, 7'b0000010};

    #3;
    chk("reset.pc", 32'(pc), 32'h0);
    chk("reset.mm", 32'(MM), 32'h1);
    chk("reset.rw", 32'(RW), 32'h0);
    chk("reset.mw", 32'(MW), 32'h0);
    @(posedge clk_main); #1;
    reset = 1'b0;

    run_instr(16'h04CA, 1'b0, 1'b0, 16'h0, "add_r3_r1_r2");
    run_instr(16'hE000, 1'b0, 1'b0, 16'h0005, "jmp5");
    run_instr(16'hC1C6, 1'b1, 1'b0, 16'h0, "brz_taken");
    run_instr(16'hE000, 1'b0, 1'b0, 16'h0005, "jmp5b");
    run_instr(16'hC1C6, 1'b0, 1'b1, 16'h0, "brz_not_taken");
    run_instr(16'hE000, 1'b0, 1'b0, 16'h0005, "jmp5c");
    run_instr(16'hC3C6, 1'b0, 1'b1, 16'h0, "brn_taken");
    run_instr(16'hE000, 1'b0, 1'b0, 16'h0000, "jmp0");
    run_instr(16'hC1C6, 1'b1, 1'b0, 16'h0, "brz_wrap");
    run_instr(16'h2310, 1'b0, 1'b0, 16'h0, "lri_r4_r2");
    run_instr(16'h401D, 1'b0, 1'b0, 16'h0, "st");
    run_instr(16'h9845, 1'b0, 1'b0, 16'h0, "ldi_r1_5");
    run_instr(16'hE008, 1'b0, 1'b0, 16'h1234, "jmp1234");

    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       ins[15:9] = {3'b000, ins[12:9]};
        1, 2:    ins[15:9] = op_tab[$urandom_range(0, 8)];
        default: ;
      endcase
      if (ins[15:9] == 7'b1111111) ins[15:9] = 7'b0111111;
      run_instr(ins, 1'($urandom), 1'($urandom), 16'($urandom), "rand");
    end

    do_reset("reset_mid_run");
    run_instr(16'hE000, 1'b0, 1'b0, 16'hFFFF, "jmpffff");
    run_instr(16'h04CA, 1'b0, 1'b0, 16'h0, "add_wrap");
    chk("pc_wrap", 32'(pc), 32'h0);
    run_instr(16'hE000, 1'b0, 1'b0, 16'hFFFF, "jmpffff_b");
    run_instr(16'hFE00, 1'b0, 1'b0, 16'h0, "hlt");
    halt_cycles(16'hFE00, 10);
    do_reset("reset_in_halt");
    run_instr(16'h04CA, 1'b0, 1'b0, 16'h0, "add_after_halt");
    running = 1'b0;
    @(posedge clk_main); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
